// File: rtl/core_pkg.sv
// Shared fetch-path definitions: data width, fetch FSM state encoding and PC reset value.
package core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BOOT  = 3'd1,
      ST_FETCH = 3'd2,
      ST_WAIT  = 3'd3,
      ST_HALT  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/ack bus and the decode-facing valid/ready instruction port.
interface fetch_ctrl_if;
   import core_pkg::*;

   logic            o_imem_req;
   logic [XLEN-1:0] o_imem_addr;
   logic            i_imem_ack;
   logic [XLEN-1:0] i_imem_rdata;
   logic            o_instr_valid;
   logic [XLEN-1:0] o_instr;
   logic [XLEN-1:0] o_instr_pc;
   logic            i_dec_ready;

   modport master (
      output o_imem_req,
      output o_imem_addr,
      input  i_imem_ack,
      input  i_imem_rdata,
      output o_instr_valid,
      output o_instr,
      output o_instr_pc,
      input  i_dec_ready
   );

   modport slave (
      input  o_imem_req,
      input  o_imem_addr,
      output i_imem_ack,
      output i_imem_rdata,
      input  o_instr_valid,
      input  o_instr,
      input  o_instr_pc,
      output i_dec_ready
   );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// Single-entry valid/ready buffer holding one fetched instruction and its PC for decode.
module fetch_buf
   import core_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr,
   input  logic            wr_en,
   input  logic [XLEN-1:0] wr_instr,
   input  logic [XLEN-1:0] wr_pc,
   input  logic            rd_ready,
   output logic            valid,
   output logic [XLEN-1:0] instr,
   output logic [XLEN-1:0] pc
);

   // Clear beats write; write beats consume so a same-cycle refill keeps valid high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         instr <= {XLEN{1'b0}};
         pc    <= {XLEN{1'b0}};
      end else if (clr) begin
         valid <= 1'b0;
      end else if (wr_en) begin
         valid <= 1'b1;
         instr <= wr_instr;
         pc    <= wr_pc;
      end else if (valid && rd_ready) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: boots the PC, runs one outstanding imem fetch, applies redirects, feeds decode.
// Optional saturating stall-cycle counter on o_stall_cnt when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
   import core_pkg::*;
`ifdef FETCH_PERF_CNT_EN
#(
   parameter int PERF_W = 32
)
`endif
(
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_boot_req,
   input  logic [XLEN-1:0]   i_boot_addr,
   input  logic              i_halt,
   input  logic              i_redirect,
   input  logic [XLEN-1:0]   i_redirect_addr,
   input  logic [XLEN-1:0]   i_pc,
   output logic              o_pc_stall,
   output logic              o_pc_load_first,
   output logic [XLEN-1:0]   o_pc_start_addr,
   output logic              o_pc_branch_true,
   output logic [XLEN-1:0]   o_pc_branch_addr,
`ifdef FETCH_PERF_CNT_EN
   output logic [PERF_W-1:0] o_stall_cnt,
`endif
   fetch_ctrl_if.master      bus
);

   fetch_state_e    state_r;
   fetch_state_e    state_s;
   logic            kill_r;
   logic            kill_s;
   logic [XLEN-1:0] start_addr_r;
   logic [XLEN-1:0] req_addr_r;

   logic            req_s;
   logic            issue_s;
   logic [XLEN-1:0] addr_s;
   logic            stall_s;
   logic            load_first_s;
   logic            branch_s;
   logic            buf_clr_s;
   logic            buf_wr_s;
   logic            consume_s;

   logic            buf_valid_s;
   logic [XLEN-1:0] buf_instr_s;
   logic [XLEN-1:0] buf_pc_s;

   assign consume_s = buf_valid_s & bus.i_dec_ready;

   // FSM state, kill flag, latched boot address and the address of the outstanding request.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r      <= ST_IDLE;
         kill_r       <= 1'b0;
         start_addr_r <= {XLEN{1'b0}};
         req_addr_r   <= RESET_PC;
      end else begin
         state_r <= state_s;
         kill_r  <= kill_s;
         if (state_s == ST_BOOT) begin
            start_addr_r <= i_boot_addr;
         end
         if (issue_s) begin
            req_addr_r <= i_pc;
         end
      end
   end

   // Next-state and PC/imem control; redirect outranks ack, ack outranks halt.
   always_comb begin
      state_s      = state_r;
      kill_s       = kill_r;
      req_s        = 1'b0;
      issue_s      = 1'b0;
      addr_s       = {XLEN{1'b0}};
      stall_s      = 1'b1;
      load_first_s = 1'b0;
      branch_s     = 1'b0;
      buf_clr_s    = 1'b0;
      buf_wr_s     = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (i_boot_req) begin
               state_s = ST_BOOT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_BOOT: begin
            load_first_s = 1'b1;
            stall_s      = 1'b0;
            buf_clr_s    = 1'b1;
            kill_s       = 1'b0;
            state_s      = ST_FETCH;
         end
         ST_FETCH: begin
            if (i_boot_req) begin
               state_s = ST_BOOT;
            end else if (i_redirect) begin
               branch_s  = 1'b1;
               stall_s   = 1'b0;
               buf_clr_s = 1'b1;
               state_s   = i_halt ? ST_HALT : ST_FETCH;
            end else if (i_halt) begin
               state_s = ST_HALT;
            end else if (buf_valid_s && !consume_s) begin
               state_s = ST_FETCH;
            end else begin
               req_s   = 1'b1;
               issue_s = 1'b1;
               addr_s  = i_pc;
               state_s = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // The request stays up through the ack cycle with the address captured at issue,
            // since a redirect moves i_pc while the old fetch is still in flight.
            req_s  = 1'b1;
            addr_s = req_addr_r;
            if (i_redirect) begin
               branch_s  = 1'b1;
               stall_s   = 1'b0;
               buf_clr_s = 1'b1;
               if (bus.i_imem_ack) begin
                  kill_s  = 1'b0;
                  state_s = ST_FETCH;
               end else begin
                  kill_s  = 1'b1;
                  state_s = ST_WAIT;
               end
            end else if (bus.i_imem_ack) begin
               state_s = ST_FETCH;
               if (kill_r) begin
                  kill_s = 1'b0;
               end else begin
                  buf_wr_s = 1'b1;
                  stall_s  = 1'b0;
               end
            end else begin
               state_s = ST_WAIT;
            end
         end
         ST_HALT: begin
            if (i_boot_req) begin
               state_s = ST_BOOT;
            end else if (i_redirect) begin
               branch_s  = 1'b1;
               stall_s   = 1'b0;
               buf_clr_s = 1'b1;
               state_s   = i_halt ? ST_HALT : ST_FETCH;
            end else if (!i_halt) begin
               state_s = ST_FETCH;
            end else begin
               state_s = ST_HALT;
            end
         end
         default: begin
            state_s = ST_IDLE;
            kill_s  = 1'b0;
         end
      endcase
   end

   fetch_buf u_buf (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clr      (buf_clr_s),
      .wr_en    (buf_wr_s),
      .wr_instr (bus.i_imem_rdata),
      .wr_pc    (i_pc),
      .rd_ready (bus.i_dec_ready),
      .valid    (buf_valid_s),
      .instr    (buf_instr_s),
      .pc       (buf_pc_s)
   );

   assign o_pc_stall       = stall_s;
   assign o_pc_load_first  = load_first_s;
   assign o_pc_start_addr  = start_addr_r;
   assign o_pc_branch_true = branch_s;
   assign o_pc_branch_addr = branch_s ? i_redirect_addr : {XLEN{1'b0}};

   assign bus.o_imem_req    = req_s;
   assign bus.o_imem_addr   = addr_s;
   assign bus.o_instr_valid = buf_valid_s;
   assign bus.o_instr       = buf_instr_s;
   assign bus.o_instr_pc    = buf_pc_s;

`ifdef FETCH_PERF_CNT_EN
   logic [PERF_W-1:0] stall_cnt_r;

   // Saturating count of stalled cycles spent in FETCH or WAIT; restarts on boot.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         stall_cnt_r <= {PERF_W{1'b0}};
      end else if (state_r == ST_BOOT) begin
         stall_cnt_r <= {PERF_W{1'b0}};
      end else if ((state_r == ST_FETCH || state_r == ST_WAIT) && stall_s
                   && (stall_cnt_r != {PERF_W{1'b1}})) begin
         stall_cnt_r <= stall_cnt_r + {{(PERF_W-1){1'b0}}, 1'b1};
      end
   end

   assign o_stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a randomized run against a program-order stream model.
module tb_fetch_ctrl;
   import core_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        boot_req;
   logic [31:0] boot_addr;
   logic        halt;
   logic        redirect;
   logic [31:0] redirect_addr;
   logic [31:0] pc_q;
   logic        stall;
   logic        load_first;
   logic [31:0] start_addr;
   logic        branch_true;
   logic [31:0] branch_addr;
   logic        dec_ready;
   logic        auto_mode;
   logic        man_ack;
   logic [31:0] man_data;
   logic        auto_ack;
   logic [31:0] auto_data;
   int          wait_cnt;
   int          checks;
   int          errors;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   fetch_ctrl_if bus ();

   assign bus.i_imem_ack   = auto_mode ? auto_ack : man_ack;
   assign bus.i_imem_rdata = auto_mode ? auto_data : man_data;
   assign bus.i_dec_ready  = dec_ready;

   fetch_ctrl dut (
      .i_clk            (clk),
      .i_rst_n          (rst_n),
      .i_boot_req       (boot_req),
      .i_boot_addr      (boot_addr),
      .i_halt           (halt),
      .i_redirect       (redirect),
      .i_redirect_addr  (redirect_addr),
      .i_pc             (pc_q),
      .o_pc_stall       (stall),
      .o_pc_load_first  (load_first),
      .o_pc_start_addr  (start_addr),
      .o_pc_branch_true (branch_true),
      .o_pc_branch_addr (branch_addr),
`ifdef FETCH_PERF_CNT_EN
      .o_stall_cnt      (stall_cnt),
`endif
      .bus              (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   // External PC register that the controller steers
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) pc_q <= 32'h0;
      else if (load_first) pc_q <= start_addr;
      else if (branch_true) pc_q <= branch_addr;
      else if (!stall) pc_q <= pc_q + 32'd4;
   end

   // Randomly delayed memory that answers each request with a one-cycle ack
   always @(posedge clk) begin
      if (!auto_mode || !rst_n) begin
         auto_ack <= 1'b0;
         wait_cnt <= 0;
      end else if (auto_ack) begin
         auto_ack <= 1'b0;
      end else if (bus.o_imem_req) begin
         if (wait_cnt == 0) begin
            auto_ack  <= 1'b1;
            auto_data <= mem_word(bus.o_imem_addr);
            wait_cnt  <= int'($urandom_range(0, 3));
         end else begin
            wait_cnt <= wait_cnt - 1;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, got timeout want finish");
      $fatal(1);
   end

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic reset_and_boot(input logic [31:0] addr);
      rst_n = 1'b0; boot_req = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
      dec_ready = 1'b0; man_ack = 1'b0; man_data = 32'h0; auto_mode = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      boot_req = 1'b1; boot_addr = addr;
      next_cycle();
      boot_req = 1'b0;
      next_cycle();
   endtask

   task automatic test_reset;
      @(posedge clk);
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %0h want 1", stall); end
      checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0h want 0", bus.o_imem_req); end
      checks++; if (load_first !== 1'b0 || branch_true !== 1'b0) begin errors++; $display("FAIL reset_pcctl: got %0h/%0h want 0/0", load_first, branch_true); end
      checks++; if (bus.o_instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h want 0", bus.o_instr_valid); end
      checks++; if (bus.o_imem_addr !== 32'h0 || start_addr !== 32'h0 || bus.o_instr !== 32'h0) begin errors++; $display("FAIL reset_data: got %h/%h/%h want 0", bus.o_imem_addr, start_addr, bus.o_instr); end
   endtask

   task automatic test_boot;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
      boot_req = 1'b1; boot_addr = 32'h100;
      @(negedge clk);
      checks++; if (stall !== 1'b1 || load_first !== 1'b0) begin errors++; $display("FAIL boot_idle: got stall %0h load %0h want 1 0", stall, load_first); end
      next_cycle();
      boot_req = 1'b0;
      @(negedge clk);
      checks++; if (load_first !== 1'b1 || stall !== 1'b0) begin errors++; $display("FAIL boot_load: got load %0h stall %0h want 1 0", load_first, stall); end
      checks++; if (start_addr !== 32'h100) begin errors++; $display("FAIL boot_start_addr: got %h want 100", start_addr); end
      checks++; if (bus.o_imem_req !== 1'b0 || branch_true !== 1'b0) begin errors++; $display("FAIL boot_noreq: got req %0h br %0h want 0 0", bus.o_imem_req, branch_true); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100) begin errors++; $display("FAIL boot_first_req: got %0h@%h want 1@100", bus.o_imem_req, bus.o_imem_addr); end
      checks++; if (load_first !== 1'b0) begin errors++; $display("FAIL boot_load_once: got %0h want 0", load_first); end
   endtask

   task automatic test_stream;
      reset_and_boot(32'h100);
      dec_ready = 1'b1;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stream_req_stall: got %0h want 1", stall); end
      next_cycle(); man_ack = 1'b1; man_data = 32'hA;
      @(negedge clk);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stream_ack_stall: got %0h want 0", stall); end
      next_cycle(); man_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b1 || bus.o_instr !== 32'hA || bus.o_instr_pc !== 32'h100) begin errors++; $display("FAIL stream_first: got %0h %h@%h want 1 a@100", bus.o_instr_valid, bus.o_instr, bus.o_instr_pc); end
      checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h104 || stall !== 1'b1) begin errors++; $display("FAIL stream_req2: got %0h@%h stall %0h want 1@104 1", bus.o_imem_req, bus.o_imem_addr, stall); end
      next_cycle(); man_ack = 1'b1; man_data = 32'hB;
      @(negedge clk);
      checks++; if (stall !== 1'b0 || bus.o_instr_valid !== 1'b0) begin errors++; $display("FAIL stream_ack2: got stall %0h valid %0h want 0 0", stall, bus.o_instr_valid); end
      next_cycle(); man_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_instr !== 32'hB || bus.o_instr_pc !== 32'h104 || bus.o_imem_addr !== 32'h108) begin errors++; $display("FAIL stream_second: got %h@%h next %h want b@104 next 108", bus.o_instr, bus.o_instr_pc, bus.o_imem_addr); end
   endtask

   task automatic test_backpressure;
      reset_and_boot(32'h100);
      next_cycle(); man_ack = 1'b1; man_data = 32'hA;
      next_cycle(); man_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (bus.o_imem_req !== 1'b0 || bus.o_instr_valid !== 1'b1 || bus.o_instr !== 32'hA || bus.o_instr_pc !== 32'h100) begin errors++; $display("FAIL bp_hold[%0d]: got req %0h v %0h %h@%h want 0 1 a@100", i, bus.o_imem_req, bus.o_instr_valid, bus.o_instr, bus.o_instr_pc); end
         next_cycle();
      end
      dec_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h104) begin errors++; $display("FAIL bp_release: got %0h@%h want 1@104", bus.o_imem_req, bus.o_imem_addr); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %0h want 0", bus.o_instr_valid); end
   endtask

   task automatic test_halt;
      reset_and_boot(32'h100);
      dec_ready = 1'b1;
      next_cycle(); man_ack = 1'b1; man_data = 32'hA;
      next_cycle(); man_ack = 1'b0; halt = 1'b1;
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL halt_enter: got req %0h stall %0h want 0 1", bus.o_imem_req, stall); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL halt_hold: got req %0h stall %0h want 0 1", bus.o_imem_req, stall); end
      next_cycle(); halt = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL halt_exit: got %0h want 0", bus.o_imem_req); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h104) begin errors++; $display("FAIL halt_resume: got %0h@%h want 1@104", bus.o_imem_req, bus.o_imem_addr); end
   endtask

   task automatic test_redirect_wait;
      reset_and_boot(32'h100);
      dec_ready = 1'b1;
      next_cycle(); redirect = 1'b1; redirect_addr = 32'h200;
      @(negedge clk);
      checks++; if (branch_true !== 1'b1 || branch_addr !== 32'h200 || stall !== 1'b0) begin errors++; $display("FAIL rw_branch: got %0h %h stall %0h want 1 200 0", branch_true, branch_addr, stall); end
      for (int i = 0; i < 3; i++) begin
         if (i == 1) redirect = 1'b0;
         checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h100) begin errors++; $display("FAIL rw_hold[%0d]: got %0h@%h want 1@100", i, bus.o_imem_req, bus.o_imem_addr); end
         next_cycle();
         redirect = 1'b0;
         @(negedge clk);
      end
      next_cycle(); man_ack = 1'b1; man_data = 32'hDEAD;
      @(negedge clk);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rw_kill_stall: got %0h want 1", stall); end
      next_cycle(); man_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h200) begin errors++; $display("FAIL rw_refetch: got v %0h req %0h@%h want 0 1@200", bus.o_instr_valid, bus.o_imem_req, bus.o_imem_addr); end
      next_cycle();
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b0) begin errors++; $display("FAIL rw_dropped: got %0h want 0", bus.o_instr_valid); end
   endtask

   task automatic test_redirect_ack;
      reset_and_boot(32'h100);
      dec_ready = 1'b1;
      next_cycle(); man_ack = 1'b1; man_data = 32'hBEEF; redirect = 1'b1; redirect_addr = 32'h300;
      @(negedge clk);
      checks++; if (branch_true !== 1'b1 || stall !== 1'b0 || load_first !== 1'b0) begin errors++; $display("FAIL ra_branch: got br %0h stall %0h load %0h want 1 0 0", branch_true, stall, load_first); end
      next_cycle(); man_ack = 1'b0; redirect = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b0 || bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== 32'h300) begin errors++; $display("FAIL ra_next: got v %0h req %0h@%h want 0 1@300", bus.o_instr_valid, bus.o_imem_req, bus.o_imem_addr); end
   endtask

   task automatic test_reset_mid_req;
      reset_and_boot(32'h100);
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %0h want 1", bus.o_imem_req); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.o_imem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rst_async: got req %0h stall %0h want 0 1", bus.o_imem_req, stall); end
      next_cycle(); rst_n = 1'b1; man_ack = 1'b1; man_data = 32'h1234;
      @(negedge clk);
      checks++; if (bus.o_imem_req !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL rst_late_ack: got req %0h stall %0h want 0 1", bus.o_imem_req, stall); end
      next_cycle(); man_ack = 1'b0;
      @(negedge clk);
      checks++; if (bus.o_instr_valid !== 1'b0 || bus.o_imem_req !== 1'b0) begin errors++; $display("FAIL rst_idle: got v %0h req %0h want 0 0", bus.o_instr_valid, bus.o_imem_req); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (stall_cnt !== 32'h0) begin errors++; $display("FAIL rst_perf: got %0d want 0", stall_cnt); end
`endif
   endtask

   task automatic test_random;
      logic [31:0] exp_pc;
      logic        prev_req;
      logic        prev_ack;
      logic [31:0] prev_addr;
      int          consumed;
      int          halt_len;
      reset_and_boot(32'h1000);
      auto_mode = 1'b1;
      exp_pc = 32'h1000; consumed = 0; halt_len = 0;
      prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;
      for (int i = 0; i < 3000; i++) begin
         redirect      = ($urandom_range(0, 19) == 0);
         redirect_addr = $urandom & 32'h0000_FFFC;
         dec_ready     = redirect ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (halt_len > 0) halt_len--;
         else if ($urandom_range(0, 39) == 0) halt_len = int'($urandom_range(1, 6));
         halt = (halt_len > 0);
         @(negedge clk);
         checks++; if (branch_true !== redirect || (redirect && branch_addr !== redirect_addr)) begin errors++; $display("FAIL rnd_branch[%0d]: got %0h %h want %0h %h", i, branch_true, branch_addr, redirect, redirect_addr); end
         checks++; if (load_first !== 1'b0) begin errors++; $display("FAIL rnd_load_first[%0d]: got %0h want 0", i, load_first); end
         if (prev_req && !prev_ack) begin
            checks++; if (bus.o_imem_req !== 1'b1 || bus.o_imem_addr !== prev_addr) begin errors++; $display("FAIL rnd_req_hold[%0d]: got %0h@%h want 1@%h", i, bus.o_imem_req, bus.o_imem_addr, prev_addr); end
         end
         if (bus.o_instr_valid && dec_ready) begin
            checks++; if (bus.o_instr_pc !== exp_pc || bus.o_instr !== mem_word(exp_pc)) begin errors++; $display("FAIL rnd_stream[%0d]: got %h@%h want %h@%h", i, bus.o_instr, bus.o_instr_pc, mem_word(exp_pc), exp_pc); end
            exp_pc = exp_pc + 32'd4;
            consumed++;
         end
         if (redirect) exp_pc = redirect_addr;
         prev_req = bus.o_imem_req; prev_ack = bus.i_imem_ack; prev_addr = bus.o_imem_addr;
         next_cycle();
      end
      checks++; if (consumed < 200) begin errors++; $display("FAIL rnd_progress: got %0d instructions want at least 200", consumed); end
      auto_mode = 1'b0; redirect = 1'b0; halt = 1'b0; dec_ready = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0; boot_req = 1'b0; boot_addr = 32'h0; halt = 1'b0; redirect = 1'b0;
      redirect_addr = 32'h0; dec_ready = 1'b0; auto_mode = 1'b0; man_ack = 1'b0; man_data = 32'h0;
      test_reset();
      test_boot();
      test_stream();
      test_backpressure();
      test_halt();
      test_redirect_wait();
      test_redirect_ack();
      test_reset_mid_req();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
